spi_handler: RTL and testbench

- SPI master between the thermostat controller and its two SPI slaves: the thermometer on chip select 0 and the program EEPROM on chip select 1.
- On a level request it runs one SPI transaction. For the thermometer it returns a 10-bit temperature; for the EEPROM it returns the full program image.
- Ready is returned through a 4-phase handshake.
- Runs from the 20 kHz system clock and generates a 10 kHz SPI clock.

---
 rtl/spi_handler_pkg.sv | 26 ++
 rtl/spi_handler_if.sv | 30 +++
 rtl/spi_handler_sclk_gen.sv | 51 +++++
 rtl/spi_handler.sv | 199 +++++++++++++++++++
 tb/tb_spi_handler.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spi_handler_pkg.sv
// Shared types and constants for the thermostat SPI master.
package spi_handler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_END,
        ST_DONE
    } state_e;

    localparam logic [7:0]  THERM_CMD    = 8'h50;
    localparam logic [7:0]  PROG_CMD     = 8'h03;
    localparam logic [15:0] EEPROM_ADDR  = 16'h0000;
    localparam int          TEMP_FRAME_W = 16;
    localparam int          TEMP_MSB     = 15;
    localparam int          TEMP_LSB     = 6;

    // 8.2 fixed-point temperature field of a thermometer frame
    function automatic logic [9:0] temp_field(input logic [TEMP_FRAME_W-1:0] f);
        return f[TEMP_MSB:TEMP_LSB];
    endfunction

endpackage

// File: rtl/spi_handler_if.sv
// Request/response and SPI bus signals of spi_handler.
interface spi_handler_if #(
    parameter int P_PROG_BITS = 16896
);
    logic                   i_read_program;
    logic [P_PROG_BITS-1:0] o_program_data;
    logic                   o_program_ready;
    logic                   i_read_therm;
    logic [9:0]             o_temperature;
    logic                   o_therm_ready;
    logic                   i_spi_disconnect;
    logic                   o_spi_clk;
    logic [1:0]             o_spi_cs_n;
    logic                   o_spi_si;
    logic                   i_spi_so;

    // Requester / SPI slave side
    modport master (
        output i_read_program, i_read_therm, i_spi_disconnect, i_spi_so,
        input  o_program_data, o_program_ready, o_temperature, o_therm_ready,
               o_spi_clk, o_spi_cs_n, o_spi_si
    );

    // spi_handler side
    modport slave (
        input  i_read_program, i_read_therm, i_spi_disconnect, i_spi_so,
        output o_program_data, o_program_ready, o_temperature, o_therm_ready,
               o_spi_clk, o_spi_cs_n, o_spi_si
    );
endinterface

// File: rtl/spi_handler_sclk_gen.sv
// SPI clock divider. tick_o marks the end of each half-period while enabled;
// with tog_i set the clock toggles there, flagged by rise_o / fall_o.
// Dropping en_i parks the clock low on the next system clock.
module spi_sclk_gen #(
    parameter int P_HALF_PERIOD = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic tog_i,
    output logic sclk_o,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = (P_HALF_PERIOD > 1) ? $clog2(P_HALF_PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;

    assign tick_o = en_i && (cnt_q == CW'(P_HALF_PERIOD - 1));
    assign rise_o = tick_o && tog_i && !clk_q;
    assign fall_o = tick_o && tog_i && clk_q;
    assign sclk_o = clk_q;

    // Half-period counter and clock toggle
    always_comb begin
        cnt_d = cnt_q;
        clk_d = clk_q;
        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (tick_o) begin
            cnt_d = '0;
            if (tog_i) clk_d = !clk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end
endmodule

// File: rtl/spi_handler.sv
// SPI master for the thermometer (cs 0) and program EEPROM (cs 1).
// Define SPI_HANDLER_PROGRAM_READ_EN to build the EEPROM read path;
// P_PROG_BITS must then be at least 16.
module spi_handler
    import spi_handler_pkg::*;
#(
    parameter int         P_HALF_PERIOD = 1,
    parameter int         P_PROG_BITS   = 16896,
    parameter logic [7:0] P_THERM_CMD   = THERM_CMD,
    parameter logic [7:0] P_PROG_CMD    = PROG_CMD
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    spi_handler_if.slave  bus
);
`ifdef SPI_HANDLER_PROGRAM_READ_EN
    localparam int RXW = P_PROG_BITS;
`else
    localparam int RXW = TEMP_FRAME_W;
`endif
    localparam int BW = $clog2((P_PROG_BITS > 16) ? P_PROG_BITS : 16) + 1;

    state_e          state_q, state_d;
    logic            cs_act_q, cs_act_d;
    logic [23:0]     tx_q, tx_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [RXW-1:0]  rx_q, rx_d;
    logic [9:0]      temp_q, temp_d;
    logic            tready_q, tready_d;
    logic            running, shifting, disc;
    logic            sclk, tick, rise, fall;
    logic            req_t, req_p, cur_req;

    assign req_t    = bus.i_read_therm;
    assign disc     = bus.i_spi_disconnect;
    assign running  = state_q inside {ST_SETUP, ST_CMD, ST_ADDR, ST_READ, ST_END};
    assign shifting = state_q inside {ST_CMD, ST_ADDR, ST_READ};

`ifdef SPI_HANDLER_PROGRAM_READ_EN
    logic                   sel_q, sel_d;
    logic                   pready_q, pready_d;
    logic [P_PROG_BITS-1:0] prog_q, prog_d;

    assign req_p               = bus.i_read_program;
    assign cur_req             = sel_q ? req_p : req_t;
    assign bus.o_spi_cs_n      = !cs_act_q ? 2'b11 : (sel_q ? 2'b01 : 2'b10);
    assign bus.o_program_data  = prog_q;
    assign bus.o_program_ready = pready_q;
`else
    logic unused_prog_req;

    assign unused_prog_req     = bus.i_read_program;
    assign req_p               = 1'b0;
    assign cur_req             = req_t;
    assign bus.o_spi_cs_n      = {1'b1, !cs_act_q};
    assign bus.o_program_data  = '0;
    assign bus.o_program_ready = 1'b0;
`endif

    assign bus.o_spi_clk     = sclk;
    assign bus.o_spi_si      = tx_q[23];
    assign bus.o_temperature = temp_q;
    assign bus.o_therm_ready = tready_q;

    // Disconnect drops the enable at once so the clock parks low with the abort
    spi_sclk_gen #(.P_HALF_PERIOD(P_HALF_PERIOD)) u_sclk (
        .clk_i  (i_clk),
        .rst_ni (i_reset_n),
        .en_i   (running && !disc),
        .tog_i  (shifting),
        .sclk_o (sclk),
        .tick_o (tick),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Transaction sequencing: shift MOSI on fall, sample MISO on rise
    always_comb begin
        state_d  = state_q;
        cs_act_d = cs_act_q;
        tx_d     = tx_q;
        bit_d    = bit_q;
        rx_d     = rx_q;
        temp_d   = temp_q;
        tready_d = tready_q;
`ifdef SPI_HANDLER_PROGRAM_READ_EN
        sel_d    = sel_q;
        pready_d = pready_q;
        prog_d   = prog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!disc && (req_t || req_p)) begin
                    state_d  = ST_SETUP;
                    cs_act_d = 1'b1;
                    bit_d    = BW'(7);
                    tx_d     = {P_THERM_CMD, 16'h0000};
`ifdef SPI_HANDLER_PROGRAM_READ_EN
                    sel_d    = !req_t;
                    if (!req_t) tx_d = {P_PROG_CMD, EEPROM_ADDR};
`endif
                end
            end
            ST_SETUP: if (tick) state_d = ST_CMD;
            ST_CMD, ST_ADDR: begin
                if (fall) begin
                    tx_d  = tx_q << 1;
                    bit_d = bit_q - BW'(1);
                    if (bit_q == '0) begin
`ifdef SPI_HANDLER_PROGRAM_READ_EN
                        if (sel_q && state_q == ST_CMD) begin
                            state_d = ST_ADDR;
                            bit_d   = BW'(15);
                        end else if (sel_q) begin
                            state_d = ST_READ;
                            bit_d   = BW'(P_PROG_BITS - 1);
                        end else
`endif
                        begin
                            state_d = ST_READ;
                            bit_d   = BW'(TEMP_FRAME_W - 1);
                        end
                    end
                end
            end
            ST_READ: begin
                if (rise) rx_d = {rx_q[RXW-2:0], bus.i_spi_so};
                if (fall) begin
                    bit_d = bit_q - BW'(1);
                    if (bit_q == '0) state_d = ST_END;
                end
            end
            ST_END: begin
                if (tick) begin
                    state_d  = ST_DONE;
                    cs_act_d = 1'b0;
`ifdef SPI_HANDLER_PROGRAM_READ_EN
                    if (sel_q) begin
                        pready_d = 1'b1;
                        prog_d   = rx_q;
                    end else
`endif
                    begin
                        tready_d = 1'b1;
                        temp_d   = temp_field(rx_q[TEMP_FRAME_W-1:0]);
                    end
                end
            end
            ST_DONE: begin
                if (!cur_req) begin
                    state_d  = ST_IDLE;
                    tready_d = 1'b0;
`ifdef SPI_HANDLER_PROGRAM_READ_EN
                    pready_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Disconnect during a transaction parks the bus and drops partial data
        if (running && disc) begin
            state_d  = ST_IDLE;
            cs_act_d = 1'b0;
            tx_d     = '0;
            rx_d     = '0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            cs_act_q <= 1'b0;
            tx_q     <= '0;
            bit_q    <= '0;
            rx_q     <= '0;
            temp_q   <= '0;
            tready_q <= 1'b0;
`ifdef SPI_HANDLER_PROGRAM_READ_EN
            sel_q    <= 1'b0;
            pready_q <= 1'b0;
            prog_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cs_act_q <= cs_act_d;
            tx_q     <= tx_d;
            bit_q    <= bit_d;
            rx_q     <= rx_d;
            temp_q   <= temp_d;
            tready_q <= tready_d;
`ifdef SPI_HANDLER_PROGRAM_READ_EN
            sel_q    <= sel_d;
            pready_q <= pready_d;
            prog_q   <= prog_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_handler.sv
// Directed bench for spi_handler with a behavioural thermometer/EEPROM slave.
module tb_spi_handler;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Slave model state
    int          nrise, nfall, hdr;
    logic [63:0] mosi_cap;
    logic [31:0] sh;
    logic [15:0] therm_word;
    logic [31:0] prog_word;
    bit          cs1_seen = 1'b0;
    bit          both_low = 1'b0;

    always #5 clk = !clk;

    spi_handler_if #(.P_PROG_BITS(32)) bus ();

    spi_handler #(.P_HALF_PERIOD(1), .P_PROG_BITS(32)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Capture MOSI on SPI rising edges
    always @(posedge bus.o_spi_clk) begin
        if (bus.o_spi_cs_n != 2'b11) begin
            mosi_cap = {mosi_cap[62:0], bus.o_spi_si};
            nrise++;
        end
    end

    // Slave drives MISO after each falling edge once its header is received
    always @(negedge bus.o_spi_clk) begin
        if (bus.o_spi_cs_n != 2'b11) begin
            nfall++;
            hdr = bus.o_spi_cs_n[0] ? 24 : 8;
            if (nfall == hdr) sh = bus.o_spi_cs_n[0] ? prog_word : {therm_word, 16'h0000};
            if (nfall >= hdr) begin
                bus.i_spi_so = sh[31];
                sh = sh << 1;
            end
        end
    end

    // Chip-select watch
    always @(negedge clk) begin
        if (bus.o_spi_cs_n == 2'b00) both_low = 1'b1;
        if (bus.o_spi_cs_n[1] == 1'b0) cs1_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nrise = 0;
        nfall = 0;
        mosi_cap = '0;
    endtask

    task automatic wait_tready(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (bus.o_therm_ready) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_pready(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (bus.o_program_ready) break;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_read_therm = 1'b0;
        bus.i_read_program = 1'b0;
        bus.i_spi_disconnect = 1'b0;
        bus.i_spi_so = 1'b0;
        therm_word = 16'h1980;
        prog_word = 32'hDEADBEEF;
        clr();

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(bus.o_spi_cs_n), 64'h3);
        chk("rst_clk", 64'(bus.o_spi_clk), 64'h0);
        chk("rst_si", 64'(bus.o_spi_si), 64'h0);
        chk("rst_tready", 64'(bus.o_therm_ready), 64'h0);
        chk("rst_pready", 64'(bus.o_program_ready), 64'h0);
        chk("rst_temp", 64'(bus.o_temperature), 64'h0);
        chk("rst_prog", 64'(bus.o_program_data), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Temperature read: 16'h1980 -> 25.5 C
        clr();
        bus.i_read_therm = 1'b1;
        @(negedge clk);
        chk("t1_cs_setup", 64'(bus.o_spi_cs_n), 64'h2);
        chk("t1_clk_setup", 64'(bus.o_spi_clk), 64'h0);
        wait_tready(200);
        chk("t1_ready", 64'(bus.o_therm_ready), 64'h1);
        chk("t1_temp", 64'(bus.o_temperature), 64'h066);
        chk("t1_cs_done", 64'(bus.o_spi_cs_n), 64'h3);
        chk("t1_mosi", mosi_cap, 64'h0000_0000_0050_0000);
        chk("t1_nrise", 64'(nrise), 64'd24);

        // Request held: ready holds, no new transaction
        repeat (5) @(negedge clk);
        chk("hold_ready", 64'(bus.o_therm_ready), 64'h1);
        chk("hold_cs", 64'(bus.o_spi_cs_n), 64'h3);
        chk("hold_nrise", 64'(nrise), 64'd24);
        bus.i_read_therm = 1'b0;
        @(negedge clk);
        chk("t1_ready_drop", 64'(bus.o_therm_ready), 64'h0);
        @(negedge clk);

        // Simultaneous requests: thermometer first (16'h0C40 -> 12.25 C)
        therm_word = 16'h0C40;
        clr();
        bus.i_read_therm = 1'b1;
        bus.i_read_program = 1'b1;
        @(negedge clk);
        chk("sim_cs_therm", 64'(bus.o_spi_cs_n), 64'h2);
        wait_tready(200);
        chk("sim_tready", 64'(bus.o_therm_ready), 64'h1);
        chk("sim_temp", 64'(bus.o_temperature), 64'h031);
        chk("sim_mosi", mosi_cap, 64'h0000_0000_0050_0000);
        clr();
        bus.i_read_therm = 1'b0;
        @(negedge clk);
        chk("sim_tready_drop", 64'(bus.o_therm_ready), 64'h0);
`ifdef SPI_HANDLER_PROGRAM_READ_EN
        wait_pready(400);
        chk("prog_ready", 64'(bus.o_program_ready), 64'h1);
        chk("prog_data", 64'(bus.o_program_data), 64'hDEADBEEF);
        chk("prog_mosi", mosi_cap, 64'h0003_0000_0000_0000);
        chk("prog_nrise", 64'(nrise), 64'd56);
        chk("prog_cs1_seen", 64'(cs1_seen), 64'h1);
        bus.i_read_program = 1'b0;
        @(negedge clk);
        chk("prog_ready_drop", 64'(bus.o_program_ready), 64'h0);
        chk("prog_data_hold", 64'(bus.o_program_data), 64'hDEADBEEF);
`else
        repeat (150) @(negedge clk);
        chk("noprog_ready", 64'(bus.o_program_ready), 64'h0);
        chk("noprog_cs1", 64'(cs1_seen), 64'h0);
        chk("noprog_cs", 64'(bus.o_spi_cs_n), 64'h3);
        chk("noprog_nrise", 64'(nrise), 64'd0);
        chk("noprog_data", 64'(bus.o_program_data), 64'h0);
        bus.i_read_program = 1'b0;
`endif
        @(negedge clk);

        // Disconnect mid-read, then retry (16'hFFC0 -> 10'h3FF)
        therm_word = 16'hFFC0;
        clr();
        bus.i_read_therm = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (nrise >= 12) break;
            @(negedge clk);
        end
        chk("disc_in_read", 64'(nrise >= 12), 64'h1);
        bus.i_spi_disconnect = 1'b1;
        @(negedge clk);
        chk("disc_cs", 64'(bus.o_spi_cs_n), 64'h3);
        chk("disc_clk", 64'(bus.o_spi_clk), 64'h0);
        chk("disc_si", 64'(bus.o_spi_si), 64'h0);
        repeat (10) @(negedge clk);
        chk("disc_tready", 64'(bus.o_therm_ready), 64'h0);
        chk("disc_temp", 64'(bus.o_temperature), 64'h031);
        chk("disc_cs_idle", 64'(bus.o_spi_cs_n), 64'h3);
        clr();
        bus.i_spi_disconnect = 1'b0;
        wait_tready(200);
        chk("retry_ready", 64'(bus.o_therm_ready), 64'h1);
        chk("retry_temp", 64'(bus.o_temperature), 64'h3FF);
        chk("retry_nrise", 64'(nrise), 64'd24);
        bus.i_read_therm = 1'b0;
        @(negedge clk);
        chk("retry_ready_drop", 64'(bus.o_therm_ready), 64'h0);

        chk("cs_exclusive", 64'(both_low), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
